// File: rtl/ledstring_pkg.sv
// rtl/ledstring_pkg.sv - shared state type, pixel field offsets and widths for the LED-string frame sequencer
package ledstring_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        PIX_RD,
        PIX_LD,
        PIX,
        EOF,
        FIN
    } sched_state_t;

    // {red, grn, blu} packing of a pixel RAM word
    localparam int RED_HI = 23;
    localparam int GRN_HI = 15;
    localparam int BLU_HI = 7;

    localparam int GLO_W     = 5;
    localparam int COL_W     = 8;
    // one end frame flushes 64 LEDs (32 clock edges per frame, half an edge per LED)
    localparam int EOF_SHIFT = 6;

endpackage

// File: rtl/ledstring_refresh_timer.sv
// rtl/ledstring_refresh_timer.sv - free-running refresh period counter with a one-deep pending flag (LEDSTRING_SCHED_AUTOREFRESH_EN)
`ifdef LEDSTRING_SCHED_AUTOREFRESH_EN
module ledstring_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 600000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic consume,
    output logic pending
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (cnt == '0);

    // Period counter reloads on expiry; pending remembers at most one launch until IDLE takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= RELOAD;
            pending <= 1'b0;
        end else begin
            cnt     <= expire ? RELOAD : cnt - 1'b1;
            pending <= expire | (pending & ~consume);
        end
    end

endmodule
`endif

// File: rtl/ledstring_sched.sv
// rtl/ledstring_sched.sv - APA102 frame sequencer: start frame, NUM pixels from RAM, end frames; auto-refresh under LEDSTRING_SCHED_AUTOREFRESH_EN
module ledstring_sched
    import ledstring_pkg::*;
#(
    parameter int          AW             = 8,
    parameter int unsigned REFRESH_CYCLES = 600000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW:0]      num_leds,
    input  logic [GLO_W-1:0] glo,
    output logic             busy,
    output logic             done,
    output logic             pix_rd,
    output logic [AW-1:0]    pix_addr,
    input  logic [23:0]      pix_data,
    output logic             ls_framing,
    output logic             ls_se_frame,
    output logic [GLO_W-1:0] ls_dat_glo,
    output logic [COL_W-1:0] ls_dat_red,
    output logic [COL_W-1:0] ls_dat_grn,
    output logic [COL_W-1:0] ls_dat_blu,
    output logic             ls_valid,
    input  logic             ls_ack
);

    localparam logic [AW:0] MAX_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    sched_state_t     state_q, state_d;
    logic             busy_d, done_d, pix_rd_d, framing_d, se_d, valid_d;
    logic [AW-1:0]    pix_addr_d;
    logic [GLO_W-1:0] dat_glo_d, glo_q, glo_d;
    logic [COL_W-1:0] red_d, grn_d, blu_d;
    logic [AW:0]      cnt_q, cnt_d, idx_q, idx_d, eof_q, eof_d;
    logic [AW:0]      cnt_sat, eof_calc, idx_inc;
    logic [AW+1:0]    eof_sum;
    logic             trig;

    // Counts above the RAM depth clamp to the RAM depth so the index never wraps
    assign cnt_sat  = (num_leds > MAX_CNT) ? MAX_CNT : num_leds;
    assign eof_sum  = {1'b0, cnt_sat} + (AW+2)'(63);
    assign eof_calc = (cnt_sat == '0) ? CNT_ONE : (AW+1)'(eof_sum >> EOF_SHIFT);
    assign idx_inc  = idx_q + 1'b1;

`ifdef LEDSTRING_SCHED_AUTOREFRESH_EN
    logic pending;
    logic consume;

    // Any trigger seen in IDLE (explicit or timed) clears the pending launch
    assign consume = (state_q == IDLE);
    assign trig    = start | pending;

    ledstring_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh (
        .clk    (clk),
        .rst_n  (rst_n),
        .consume(consume),
        .pending(pending)
    );
`else
    logic [31:0] unused_refresh;
    assign unused_refresh = REFRESH_CYCLES;
    assign trig           = start;
`endif

    // State, latched transfer parameters and all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pix_rd      <= 1'b0;
            pix_addr    <= '0;
            ls_framing  <= 1'b0;
            ls_se_frame <= 1'b0;
            ls_dat_glo  <= '0;
            ls_dat_red  <= '0;
            ls_dat_grn  <= '0;
            ls_dat_blu  <= '0;
            ls_valid    <= 1'b0;
            cnt_q       <= '0;
            glo_q       <= '0;
            idx_q       <= '0;
            eof_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= busy_d;
            done        <= done_d;
            pix_rd      <= pix_rd_d;
            pix_addr    <= pix_addr_d;
            ls_framing  <= framing_d;
            ls_se_frame <= se_d;
            ls_dat_glo  <= dat_glo_d;
            ls_dat_red  <= red_d;
            ls_dat_grn  <= grn_d;
            ls_dat_blu  <= blu_d;
            ls_valid    <= valid_d;
            cnt_q       <= cnt_d;
            glo_q       <= glo_d;
            idx_q       <= idx_d;
            eof_q       <= eof_d;
        end
    end

    // Next state and next output values; outputs hold unless a state changes them
    always_comb begin
        state_d    = state_q;
        busy_d     = busy;
        done_d     = 1'b0;
        pix_rd_d   = 1'b0;
        pix_addr_d = pix_addr;
        framing_d  = ls_framing;
        se_d       = ls_se_frame;
        valid_d    = ls_valid;
        dat_glo_d  = ls_dat_glo;
        red_d      = ls_dat_red;
        grn_d      = ls_dat_grn;
        blu_d      = ls_dat_blu;
        cnt_d      = cnt_q;
        glo_d      = glo_q;
        idx_d      = idx_q;
        eof_d      = eof_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    cnt_d     = cnt_sat;
                    glo_d     = glo;
                    idx_d     = '0;
                    eof_d     = eof_calc;
                    busy_d    = 1'b1;
                    framing_d = 1'b1;
                    se_d      = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = SOF;
                end
            end
            SOF: begin
                if (ls_valid && ls_ack) begin
                    valid_d = 1'b0;
                    if (cnt_q != '0) begin
                        pix_rd_d   = 1'b1;
                        pix_addr_d = idx_q[AW-1:0];
                        state_d    = PIX_RD;
                    end else begin
                        state_d = EOF;
                    end
                end
            end
            PIX_RD: state_d = PIX_LD;
            PIX_LD: begin
                red_d     = pix_data[RED_HI -: COL_W];
                grn_d     = pix_data[GRN_HI -: COL_W];
                blu_d     = pix_data[BLU_HI -: COL_W];
                dat_glo_d = glo_q;
                framing_d = 1'b0;
                se_d      = 1'b0;
                valid_d   = 1'b1;
                state_d   = PIX;
            end
            PIX: begin
                if (ls_valid && ls_ack) begin
                    valid_d = 1'b0;
                    idx_d   = idx_inc;
                    if (idx_inc == cnt_q) begin
                        state_d = EOF;
                    end else begin
                        pix_rd_d   = 1'b1;
                        pix_addr_d = idx_inc[AW-1:0];
                        state_d    = PIX_RD;
                    end
                end
            end
            EOF: begin
                // valid rests low for one cycle after every ack before the next end frame
                if (!ls_valid) begin
                    framing_d = 1'b1;
                    se_d      = 1'b1;
                    valid_d   = 1'b1;
                end else if (ls_ack) begin
                    valid_d = 1'b0;
                    if (eof_q <= CNT_ONE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        eof_d = eof_q - 1'b1;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
